// File: rtl/ad9517_pkg.sv
// ad9517_pkg
// Shared definitions for the AD9517 SPI master and its configuration
// sequencer: frame geometry, the serial engine state encoding and the
// expected part ID byte.
package ad9517_pkg;

    // Serial engine states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    localparam int FRAME_W = 24;                // instruction + data
    localparam int INSTR_W = 16;                // instruction word width
    localparam int DATA_W  = FRAME_W - INSTR_W; // data byte width
    localparam int RW_BIT  = 23;                // 1 = read, 0 = write

    // Part ID returned by the AD9517 ID register; the sequencer compares
    // the read-back byte against this value.
    localparam logic [7:0] AD9517_ID = 8'h53;

endpackage

// File: rtl/ad9517_sclk_gen.sv
// ad9517_sclk_gen
// Serial clock generator. While enabled it produces a mode-0 SCLK level
// (CLK_DIV clk cycles low, then CLK_DIV cycles high) together with
// one-cycle enables marking the clk edge on which SCLK rises or falls.
// When disabled the divider and the SCLK level are held cleared.
//
// Ports:
//   clk        in  : system clock
//   rst        in  : asynchronous active-high reset
//   en         in  : run the divider (high only while shifting)
//   sclk       out : registered SCLK level, idle low
//   rise_tick  out : high in the cycle whose closing edge raises SCLK
//   fall_tick  out : high in the cycle whose closing edge lowers SCLK
module ad9517_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] div_cnt_reg;
    logic             sclk_reg;
    logic             half_done;

    // Last cycle of the current SCLK half-period.
    assign half_done = en && (div_cnt_reg == CNT_W'(CLK_DIV - 1));
    assign rise_tick = half_done && !sclk_reg;
    assign fall_tick = half_done && sclk_reg;
    assign sclk      = sclk_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
        end else if (!en) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
        end else if (half_done) begin
            div_cnt_reg <= '0;
            sclk_reg    <= ~sclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ad9517_spi_master.sv
// ad9517_spi_master
// Serial engine between the AD9517 configuration sequencer and the SPI
// pins. A one-cycle write or read pulse latches a 24-bit frame
// (16-bit instruction, 8-bit data), which is shifted out MSB first on a
// mode-0 bus framed by CSN. Bit 23 of the transmitted frame is replaced
// by the read flag. On reads the last 8 bits are captured from SDI and
// presented on o_spi_rd_data with a one-cycle o_spi_rd_valid pulse.
// Every output is a register, so there is no input-to-output path.
//
// Ports:
//   clk             in  : system clock
//   rst             in  : asynchronous active-high reset
//   i_spi_wr_cmd    in  : one-cycle write request (wins over read)
//   i_spi_rd_cmd    in  : one-cycle read request
//   i_spi_wr_data   in  : [23:8] instruction, [7:0] write data
//   o_spi_rd_data   out : last byte read
//   o_spi_rd_valid  out : one-cycle pulse when o_spi_rd_data updates
//   o_spi_busy      out : transaction in progress (SETUP..GAP)
//   o_spi_csn       out : chip select, active low
//   o_spi_sclk      out : serial clock, idle low
//   o_spi_sdo       out : serial data to device SDIO
//   o_spi_sdo_oe    out : SDIO driver enable for 3-wire use
//   i_spi_sdi       in  : serial data from device
module ad9517_spi_master
    import ad9517_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_spi_wr_cmd,
    input  logic                i_spi_rd_cmd,
    input  logic [FRAME_W-1:0]  i_spi_wr_data,
    output logic [DATA_W-1:0]   o_spi_rd_data,
    output logic                o_spi_rd_valid,
    output logic                o_spi_busy,
    output logic                o_spi_csn,
    output logic                o_spi_sclk,
    output logic                o_spi_sdo,
    output logic                o_spi_sdo_oe,
    input  logic                i_spi_sdi
);

    localparam int BIT_W   = 5;
    localparam int PHASE_W = 16;

    spi_state_t          state_reg, state_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [PHASE_W-1:0]  phase_reg, phase_next;
    logic [FRAME_W-1:0]  tx_reg, tx_next;
    logic [DATA_W-1:0]   rx_reg, rx_next;
    logic                rd_flag_reg, rd_flag_next;
    logic [DATA_W-1:0]   rd_data_reg, rd_data_next;
    logic                rd_valid_reg, rd_valid_next;
    logic                busy_reg, busy_next;
    logic                csn_reg, csn_next;
    logic                sdo_reg, sdo_next;
    logic                sdo_oe_reg, sdo_oe_next;

    logic                rise_tick;
    logic                fall_tick;
    logic                sclk_level;

    ad9517_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state_reg == SHIFT),
        .sclk      (sclk_level),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // ------------------------------------------------------------------
    // Next-state, datapath and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        phase_next    = phase_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        rd_flag_next  = rd_flag_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_spi_wr_cmd || i_spi_rd_cmd) begin
                    // A simultaneous write and read performs the write.
                    rd_flag_next    = ~i_spi_wr_cmd;
                    tx_next         = i_spi_wr_data;
                    tx_next[RW_BIT] = ~i_spi_wr_cmd;
                    rx_next         = '0;
                    bit_cnt_next    = '0;
                    phase_next      = '0;
                    state_next      = SETUP;
                end
            end

            SETUP: begin
                if (phase_reg == PHASE_W'(CS_SETUP - 1)) begin
                    phase_next = '0;
                    state_next = SHIFT;
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end

            SHIFT: begin
                // Only the data-phase bits of a read carry device data.
                if (rise_tick && rd_flag_reg && (bit_cnt_reg >= BIT_W'(INSTR_W))) begin
                    rx_next = {rx_reg[DATA_W-2:0], i_spi_sdi};
                end
                if (fall_tick) begin
                    if (bit_cnt_reg == BIT_W'(FRAME_W - 1)) begin
                        phase_next = '0;
                        state_next = HOLD;
                        if (rd_flag_reg) begin
                            rd_data_next  = rx_reg;
                            rd_valid_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                        tx_next      = {tx_reg[FRAME_W-2:0], 1'b0};
                    end
                end
            end

            HOLD: begin
                if (phase_reg == PHASE_W'(CS_HOLD - 1)) begin
                    phase_next = '0;
                    state_next = GAP;
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end

            GAP: begin
                if (phase_reg == PHASE_W'(CS_GAP - 1)) begin
                    phase_next = '0;
                    state_next = IDLE;
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Pin values are decoded from the next state so that every pin is
        // registered and changes on the same edge as the state it reflects.
        busy_next   = (state_next != IDLE);
        csn_next    = !((state_next == SETUP) || (state_next == SHIFT) ||
                        (state_next == HOLD));
        sdo_next    = ((state_next == SETUP) || (state_next == SHIFT)) ?
                      tx_next[FRAME_W-1] : 1'b0;
        // On reads the driver is released for the data byte so the device
        // can answer on the shared SDIO line.
        sdo_oe_next = (state_next == SETUP) ||
                      ((state_next == SHIFT) &&
                       !(rd_flag_next && (bit_cnt_next >= BIT_W'(INSTR_W))));
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            phase_reg    <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            rd_flag_reg  <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            csn_reg      <= 1'b1;
            sdo_reg      <= 1'b0;
            sdo_oe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            phase_reg    <= phase_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            rd_flag_reg  <= rd_flag_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
            busy_reg     <= busy_next;
            csn_reg      <= csn_next;
            sdo_reg      <= sdo_next;
            sdo_oe_reg   <= sdo_oe_next;
        end
    end

    assign o_spi_rd_data  = rd_data_reg;
    assign o_spi_rd_valid = rd_valid_reg;
    assign o_spi_busy     = busy_reg;
    assign o_spi_csn      = csn_reg;
    assign o_spi_sclk     = sclk_level;
    assign o_spi_sdo      = sdo_reg;
    assign o_spi_sdo_oe   = sdo_oe_reg;

endmodule

// File: tb/tb_ad9517_spi_master.sv
// tb_ad9517_spi_master
// Bench for ad9517_spi_master. Two instances: index 0 uses the default
// timing parameters, index 1 uses CLK_DIV=1 and one-cycle CS phases.
// A per-instance bus monitor and device model samples the pins on the
// falling clk edge, collects the SDO stream and SDO_OE at each SCLK rise,
// counts busy / CSN-low cycles, and returns a programmable byte on SDI.
module tb_ad9517_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        wr_cmd   [2];
    logic        rd_cmd   [2];
    logic [23:0] wr_data  [2];
    logic [7:0]  rd_data  [2];
    logic        rd_valid [2];
    logic        busy     [2];
    logic        csn      [2];
    logic        sclk     [2];
    logic        sdo      [2];
    logic        sdo_oe   [2];
    logic        sdi      [2];
    logic [7:0]  dev_byte [2];

    ad9517_spi_master u_dut_def (
        .clk            (clk),
        .rst            (rst[0]),
        .i_spi_wr_cmd   (wr_cmd[0]),
        .i_spi_rd_cmd   (rd_cmd[0]),
        .i_spi_wr_data  (wr_data[0]),
        .o_spi_rd_data  (rd_data[0]),
        .o_spi_rd_valid (rd_valid[0]),
        .o_spi_busy     (busy[0]),
        .o_spi_csn      (csn[0]),
        .o_spi_sclk     (sclk[0]),
        .o_spi_sdo      (sdo[0]),
        .o_spi_sdo_oe   (sdo_oe[0]),
        .i_spi_sdi      (sdi[0])
    );

    ad9517_spi_master #(
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .CS_GAP   (1)
    ) u_dut_fast (
        .clk            (clk),
        .rst            (rst[1]),
        .i_spi_wr_cmd   (wr_cmd[1]),
        .i_spi_rd_cmd   (rd_cmd[1]),
        .i_spi_wr_data  (wr_data[1]),
        .o_spi_rd_data  (rd_data[1]),
        .o_spi_rd_valid (rd_valid[1]),
        .o_spi_busy     (busy[1]),
        .o_spi_csn      (csn[1]),
        .o_spi_sclk     (sclk[1]),
        .o_spi_sdo      (sdo[1]),
        .o_spi_sdo_oe   (sdo_oe[1]),
        .i_spi_sdi      (sdi[1])
    );

    // Expected per-instance frame timing (hand computed).
    //   busy  = CS_SETUP + 48*CLK_DIV + CS_HOLD + CS_GAP
    //   csn   = CS_SETUP + 48*CLK_DIV + CS_HOLD
    //   rv    = CS_SETUP + 48*CLK_DIV + 1 (cycle 1 = first busy cycle)
    int exp_busy   [2] = '{200, 51};
    int exp_csn    [2] = '{196, 50};
    int exp_rv_cyc [2] = '{195, 50};
    int exp_period [2] = '{8, 2};

    // ------------------------------------------------------------------
    // Bus monitor / device model
    // ------------------------------------------------------------------
    int          cyc       [2] = '{0, 0};
    int          busy_cnt  [2] = '{0, 0};
    int          csn_low   [2] = '{0, 0};
    int          rise_cnt  [2] = '{0, 0};
    int          rv_cnt    [2] = '{0, 0};
    int          rv_cyc    [2] = '{0, 0};
    int          last_rise [2] = '{0, 0};
    int          period    [2] = '{0, 0};
    int          hi_run    [2] = '{0, 0};
    int          gap_last  [2] = '{0, 0};
    logic [23:0] cap       [2] = '{24'h0, 24'h0};
    logic [23:0] oe_cap    [2] = '{24'h0, 24'h0};
    logic        prev_busy [2] = '{1'b0, 1'b0};
    logic        prev_sclk [2] = '{1'b0, 1'b0};
    logic        prev_csn  [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (busy[d] && !prev_busy[d]) begin
                cyc[d]       <= 1;
                busy_cnt[d]  <= 1;
                csn_low[d]   <= csn[d] ? 0 : 1;
                rise_cnt[d]  <= 0;
                rv_cnt[d]    <= 0;
                rv_cyc[d]    <= 0;
                last_rise[d] <= 0;
                period[d]    <= 0;
                cap[d]       <= 24'h0;
                oe_cap[d]    <= 24'h0;
            end else begin
                cyc[d]      <= cyc[d] + 1;
                busy_cnt[d] <= busy_cnt[d] + (busy[d] ? 1 : 0);
                csn_low[d]  <= csn_low[d] + (csn[d] ? 0 : 1);
                if (sclk[d] && !prev_sclk[d]) begin
                    rise_cnt[d]  <= rise_cnt[d] + 1;
                    cap[d]       <= {cap[d][22:0], sdo[d]};
                    oe_cap[d]    <= {oe_cap[d][22:0], sdo_oe[d]};
                    period[d]    <= cyc[d] + 1 - last_rise[d];
                    last_rise[d] <= cyc[d] + 1;
                end
                if (rd_valid[d]) begin
                    rv_cnt[d] <= rv_cnt[d] + 1;
                    rv_cyc[d] <= cyc[d] + 1;
                end
            end
            if (csn[d]) begin
                hi_run[d] <= hi_run[d] + 1;
            end else begin
                if (prev_csn[d]) gap_last[d] <= hi_run[d];
                hi_run[d] <= 0;
            end
            prev_busy[d] <= busy[d];
            prev_sclk[d] <= sclk[d];
            prev_csn[d]  <= csn[d];
        end
    end

    // Device answers the data byte MSB first; the count seen here already
    // includes all earlier rises, so rise N samples data bit 23-N.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            sdi[d] = 1'b0;
            if (rise_cnt[d] >= 16 && rise_cnt[d] < 24)
                sdi[d] = dev_byte[d][23 - rise_cnt[d]];
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input int d, input logic wr, input logic rd, input logic [23:0] data);
        @(posedge clk);
        #1;
        wr_cmd[d]  = wr;
        rd_cmd[d]  = rd;
        wr_data[d] = data;
        @(posedge clk);
        #1;
        wr_cmd[d] = 1'b0;
        rd_cmd[d] = 1'b0;
    endtask

    // Returns just after the falling edge of the first cycle with busy=0.
    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy[d] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("idle_timeout", {31'd0, busy[d]}, 32'd0);
    endtask

    task automatic check_frame(input int d, input logic [23:0] frame, input logic [23:0] e_stream,
                               input logic [23:0] e_oe, input logic [7:0] e_rd, input int e_rv,
                               input logic is_rd);
        $display("txn dut=%0d frame=%06h rd=%0d stream=%06h oe=%06h rises=%0d busy=%0d csn_low=%0d rd_data=%02h rv=%0d@%0d",
                 d, frame, is_rd, cap[d], oe_cap[d], rise_cnt[d], busy_cnt[d], csn_low[d],
                 rd_data[d], rv_cnt[d], rv_cyc[d]);
        chk("sdo_stream", {8'd0, cap[d]}, {8'd0, e_stream});
        chk("sdo_oe_mask", {8'd0, oe_cap[d]}, {8'd0, e_oe});
        chk("sclk_rises", rise_cnt[d], 24);
        chk("sclk_period", period[d], exp_period[d]);
        chk("csn_low_cycles", csn_low[d], exp_csn[d]);
        chk("busy_cycles", busy_cnt[d], exp_busy[d]);
        chk("rd_valid_count", rv_cnt[d], e_rv);
        chk("rd_data", {24'd0, rd_data[d]}, {24'd0, e_rd});
        if (is_rd) chk("rd_valid_cycle", rv_cyc[d], exp_rv_cyc[d]);
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        int          d;
        logic        wr;
        logic        rd;
        logic [23:0] frame;
        logic [7:0]  dev;
        logic [23:0] exp_stream;
        logic [23:0] exp_oe;
        logic [7:0]  exp_rd;
        int          exp_rv;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // d, wr, rd, frame, device byte, stream, oe mask, rd_data, rd_valid pulses
        vecs[0] = '{0, 1'b0, 1'b1, 24'h100300, 8'h53, 24'h900300, 24'hFFFF00, 8'h53, 1};
        vecs[1] = '{0, 1'b1, 1'b0, 24'h0001A5, 8'h53, 24'h0001A5, 24'hFFFFFF, 8'h53, 0};
        vecs[2] = '{0, 1'b1, 1'b0, 24'h80ABCD, 8'h53, 24'h00ABCD, 24'hFFFFFF, 8'h53, 0};
        vecs[3] = '{0, 1'b1, 1'b1, 24'h923456, 8'h53, 24'h123456, 24'hFFFFFF, 8'h53, 0};
        vecs[4] = '{0, 1'b0, 1'b1, 24'h0000FF, 8'hA6, 24'h8000FF, 24'hFFFF00, 8'hA6, 1};
        vecs[5] = '{0, 1'b1, 1'b0, 24'h7FFFFF, 8'h53, 24'h7FFFFF, 24'hFFFFFF, 8'hA6, 0};
        vecs[6] = '{1, 1'b1, 1'b0, 24'h5A3C81, 8'h53, 24'h5A3C81, 24'hFFFFFF, 8'h00, 0};
        vecs[7] = '{1, 1'b0, 1'b1, 24'h0A5500, 8'h53, 24'h8A5500, 24'hFFFF00, 8'h53, 1};

        for (int d = 0; d < 2; d++) begin
            rst[d]      = 1'b1;
            wr_cmd[d]   = 1'b0;
            rd_cmd[d]   = 1'b0;
            wr_data[d]  = 24'h0;
            dev_byte[d] = 8'h53;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csn", {31'd0, csn[0]}, 32'd1);
        chk("rst_sclk", {31'd0, sclk[0]}, 32'd0);
        chk("rst_sdo", {31'd0, sdo[0]}, 32'd0);
        chk("rst_sdo_oe", {31'd0, sdo_oe[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid[0]}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data[0]}, 32'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy[0]}, 32'd0);

        // Reset in the middle of a read, during bit 10
        issue(0, 1'b0, 1'b1, 24'h100300);
        chk("accept_busy", {31'd0, busy[0]}, 32'd1);
        chk("accept_csn", {31'd0, csn[0]}, 32'd0);
        chk("accept_sdo_bit23", {31'd0, sdo[0]}, 32'd1);
        repeat (84) @(posedge clk);
        #1;
        chk("midrst_at_bit10", rise_cnt[0], 10);
        rst[0] = 1'b1;
        #1;
        chk("midrst_csn", {31'd0, csn[0]}, 32'd1);
        chk("midrst_sclk", {31'd0, sclk[0]}, 32'd0);
        chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
        chk("midrst_sdo_oe", {31'd0, sdo_oe[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        chk("midrst_no_rd_valid", rv_cnt[0], 0);
        chk("midrst_rd_data", {24'd0, rd_data[0]}, 32'd0);
        chk("midrst_stays_idle", {31'd0, busy[0]}, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            dev_byte[vecs[i].d] = vecs[i].dev;
            issue(vecs[i].d, vecs[i].wr, vecs[i].rd, vecs[i].frame);
            wait_idle(vecs[i].d);
            check_frame(vecs[i].d, vecs[i].frame, vecs[i].exp_stream, vecs[i].exp_oe,
                        vecs[i].exp_rd, vecs[i].exp_rv, vecs[i].rd & ~vecs[i].wr);
        end

        // Write command at cycle 50 of a frame must be ignored
        issue(0, 1'b1, 1'b0, 24'h0012C3);
        repeat (48) @(posedge clk);
        #1;
        wr_cmd[0]  = 1'b1;
        wr_data[0] = 24'hFFFFFF;
        @(posedge clk);
        #1;
        wr_cmd[0] = 1'b0;
        wait_idle(0);
        check_frame(0, 24'h0012C3, 24'h0012C3, 24'hFFFFFF, 8'hA6, 0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("ignored_cmd_not_queued", {31'd0, busy[0]}, 32'd0);

        // Back-to-back: command presented in the first cycle with busy=0
        issue(0, 1'b1, 1'b0, 24'h0A0B0C);
        wait_idle(0);
        check_frame(0, 24'h0A0B0C, 24'h0A0B0C, 24'hFFFFFF, 8'hA6, 0, 1'b0);
        wr_cmd[0]  = 1'b1;
        wr_data[0] = 24'h112233;
        @(posedge clk);
        #1;
        wr_cmd[0] = 1'b0;
        chk("b2b_accepted", {31'd0, busy[0]}, 32'd1);
        wait_idle(0);
        check_frame(0, 24'h112233, 24'h112233, 24'hFFFFFF, 8'hA6, 0, 1'b0);
        // CS_GAP cycles of GAP plus the one IDLE cycle that samples the command.
        chk("b2b_csn_high_cycles", gap_last[0], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
